fsk_edge_demodulator: RTL and testbench

Parametrised non-coherent binary FSK demodulator. It takes a 1-bit limited (hard-sliced) RX waveform and counts its transitions over each symbol period, measured in oversampling ticks. It classifies each symbol as mark (1) or space (0), flags symbols in an ambiguous dead band, and deserialises the bits into WORD_W-bit words. It sits between the RX slicer and the frame/packet logic, and replaces the fixed two-output demux stage.

---
 rtl/fsk_pkg.sv | 39 +++
 rtl/fsk_sync_edge.sv | 45 ++++
 rtl/fsk_edge_demodulator.sv | 180 ++++++++++++++++++
 tb/tb_fsk_edge_demodulator.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fsk_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fsk_pkg
//  Description : Shared types, default parameters and helpers for the
//                edge-counting FSK demodulator family.
//  Revision    : 1.0 - initial release
// ============================================================================
package fsk_pkg;

    // Demodulator control states
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fsk_state_e;

    // Default configuration
    localparam int C_OSR_DEF       = 16;
    localparam int C_SPACE_MAX_DEF = 4;
    localparam int C_MARK_MIN_DEF  = 8;
    localparam int C_WORD_W_DEF    = 8;

    // Number of bits needed to hold values 0..value-1 (minimum 1)
    function automatic int fsk_clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        if (res < 1) begin
            res = 1;
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fsk_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : fsk_sync_edge
//  Description : 2-flop synchroniser for the sliced RX line, per-tick
//                history register and qualified edge strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module fsk_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic sample_en_i,
    input  logic run_i,
    input  logic rx_i,
    output logic edge_o
);

    logic rx_meta_q;
    logic rx_s_q;
    logic prev_q;

    // Bring the asynchronous RX line into the clk domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b0;
            rx_s_q    <= 1'b0;
        end else begin
            rx_meta_q <= rx_i;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Remember the line level seen at the previous tick, in every state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
        end else if (sample_en_i) begin
            prev_q <= rx_s_q;
        end
    end

    // A transition counts only on a tick while the demodulator is running
    assign edge_o = sample_en_i & run_i & (rx_s_q ^ prev_q);

endmodule
`default_nettype wire

// File: rtl/fsk_edge_demodulator.sv
`default_nettype none
// ============================================================================
//  Module      : fsk_edge_demodulator
//  Description : Non-coherent binary FSK demodulator. Counts RX transitions
//                over OSR ticks, decides mark/space with a dead band and
//                deserialises the bits MSB-first into WORD_W-bit words.
//  Revision    : 1.0 - initial release
// ============================================================================
module fsk_edge_demodulator
    import fsk_pkg::*;
#(
    parameter int OSR       = C_OSR_DEF,
    parameter int SPACE_MAX = C_SPACE_MAX_DEF,
    parameter int MARK_MIN  = C_MARK_MIN_DEF,
    parameter int WORD_W    = C_WORD_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              sample_en,
    input  logic              rx_in,
    output logic              bit_out,
    output logic              bit_valid,
    output logic              sym_err,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid,
    output logic              busy
);

    localparam int SYM_W = fsk_clog2(OSR + 1);
    localparam int BIT_W = fsk_clog2(WORD_W);

    localparam logic [SYM_W-1:0] C_SYM_LAST  = SYM_W'(OSR - 1);
    localparam logic [SYM_W-1:0] C_OSR       = SYM_W'(OSR);
    localparam logic [SYM_W-1:0] C_SPACE_MAX = SYM_W'(SPACE_MAX);
    localparam logic [SYM_W-1:0] C_MARK_MIN  = SYM_W'(MARK_MIN);
    localparam logic [BIT_W-1:0] C_BIT_LAST  = BIT_W'(WORD_W - 1);

    fsk_state_e        state_q;
    fsk_state_e        state_d;
    logic [SYM_W-1:0]  sym_cnt_q;
    logic [SYM_W-1:0]  sym_cnt_d;
    logic [SYM_W-1:0]  edge_cnt_q;
    logic [SYM_W-1:0]  edge_cnt_d;
    logic [BIT_W-1:0]  bit_cnt_q;
    logic [BIT_W-1:0]  bit_cnt_d;
    logic [WORD_W-2:0] shift_q;
    logic [WORD_W-2:0] shift_d;
    logic [WORD_W-1:0] word_q;
    logic [WORD_W-1:0] word_d;
    logic              bit_q;
    logic              bit_d;
    logic              bit_valid_q;
    logic              bit_valid_d;
    logic              sym_err_q;
    logic              sym_err_d;
    logic              word_valid_q;
    logic              word_valid_d;

    logic              run;
    logic              edge_w;
    logic              sym_end;
    logic [SYM_W-1:0]  edge_total;
    logic              is_space;
    logic              is_mark;
    logic              decided_bit;
    logic [WORD_W-1:0] word_next;

    assign run = (state_q == ST_RUN);

    fsk_sync_edge u_sync_edge (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_en_i (sample_en),
        .run_i       (run),
        .rx_i        (rx_in),
        .edge_o      (edge_w)
    );

    // Symbol count including this tick's edge; pinned at OSR once reached
    assign edge_total = (edge_cnt_q == C_OSR) ? C_OSR : (edge_cnt_q + SYM_W'(edge_w));
    assign sym_end    = run & en & sample_en & (sym_cnt_q == C_SYM_LAST);

    // Classify the finished symbol; the dead band keeps the previous bit
    assign is_space    = (edge_total <= C_SPACE_MAX);
    assign is_mark     = (edge_total >= C_MARK_MIN);
    assign decided_bit = is_space ? 1'b0 : (is_mark ? 1'b1 : bit_q);
    assign word_next   = {shift_q, decided_bit};

    // Next control state: en alone moves between IDLE and RUN
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (en)  state_d = ST_RUN;
            ST_RUN:  if (!en) state_d = ST_IDLE;
        endcase
    end

    // Next datapath values: tick counting, decision and deserialisation
    always_comb begin
        sym_cnt_d    = sym_cnt_q;
        edge_cnt_d   = edge_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        word_d       = word_q;
        bit_d        = bit_q;
        bit_valid_d  = 1'b0;
        sym_err_d    = 1'b0;
        word_valid_d = 1'b0;

        if (!run || !en) begin
            // Idle, or leaving RUN: drop any partial symbol and partial word
            sym_cnt_d  = '0;
            edge_cnt_d = '0;
            bit_cnt_d  = '0;
        end else if (sample_en) begin
            if (sym_end) begin
                sym_cnt_d   = '0;
                edge_cnt_d  = '0;
                bit_d       = decided_bit;
                bit_valid_d = 1'b1;
                sym_err_d   = ~is_space & ~is_mark;
                shift_d     = word_next[WORD_W-2:0];
                if (bit_cnt_q == C_BIT_LAST) begin
                    word_d       = word_next;
                    word_valid_d = 1'b1;
                    bit_cnt_d    = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                end
            end else begin
                sym_cnt_d  = sym_cnt_q + SYM_W'(1);
                edge_cnt_d = edge_total;
            end
        end
    end

    // Control state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sym_cnt_q    <= '0;
            edge_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            word_q       <= '0;
            bit_q        <= 1'b0;
            bit_valid_q  <= 1'b0;
            sym_err_q    <= 1'b0;
            word_valid_q <= 1'b0;
        end else begin
            sym_cnt_q    <= sym_cnt_d;
            edge_cnt_q   <= edge_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            word_q       <= word_d;
            bit_q        <= bit_d;
            bit_valid_q  <= bit_valid_d;
            sym_err_q    <= sym_err_d;
            word_valid_q <= word_valid_d;
        end
    end

    assign bit_out    = bit_q;
    assign bit_valid  = bit_valid_q;
    assign sym_err    = sym_err_q;
    assign word_out   = word_q;
    assign word_valid = word_valid_q;
    assign busy       = run;

endmodule
`default_nettype wire

// File: tb/tb_fsk_edge_demodulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fsk_edge_demodulator
//  Description : Self-checking bench for fsk_edge_demodulator with a
//                symbol-level reference model, vector table and random phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fsk_edge_demodulator;

    localparam int OSR       = 16;
    localparam int SPACE_MAX = 4;
    localparam int MARK_MIN  = 8;
    localparam int WORD_W    = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic              sample_en = 1'b0;
    logic              rx_in = 1'b0;
    logic              bit_out;
    logic              bit_valid;
    logic              sym_err;
    logic [WORD_W-1:0] word_out;
    logic              word_valid;
    logic              busy;

    always #5 clk = ~clk;

    fsk_edge_demodulator #(
        .OSR       (OSR),
        .SPACE_MAX (SPACE_MAX),
        .MARK_MIN  (MARK_MIN),
        .WORD_W    (WORD_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .sample_en  (sample_en),
        .rx_in      (rx_in),
        .bit_out    (bit_out),
        .bit_valid  (bit_valid),
        .sym_err    (sym_err),
        .word_out   (word_out),
        .word_valid (word_valid),
        .busy       (busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ---------------- reference model (symbol level) ----------------
    bit              m_run;
    bit              m_prev;
    bit              m_d1, m_d2;      // line as seen through the 2-clk synchroniser delay
    bit              m_samples[$];    // prev level followed by the samples of the current symbol
    bit              m_wbits[$];      // decided bits of the current word, first received first
    bit              m_bit;
    logic [WORD_W-1:0] m_word;
    bit              e_bv, e_err, e_wv;

    typedef struct {
        bit              b;
        bit              err;
        bit              wv;
        logic [WORD_W-1:0] w;
        int              c;
    } ev_t;
    ev_t evq[$];

    bit cur_rx = 1'b0;
    int tphase = 0;

    task automatic model_reset();
        m_run = 0; m_prev = 0; m_d1 = 0; m_d2 = 0;
        m_samples.delete(); m_wbits.delete();
        m_bit = 0; m_word = '0;
        e_bv = 0; e_err = 0; e_wv = 0;
    endtask

    task automatic model_edge(input bit en_v, input bit se_v, input bit rx_v);
        bit s_now;
        int e;
        s_now = m_d2;
        e_bv = 0; e_err = 0; e_wv = 0;
        if (m_run) begin
            if (!en_v) begin
                m_run = 0;
                m_samples.delete();
                m_wbits.delete();
            end else if (se_v) begin
                if (m_samples.size() == 0) m_samples.push_back(m_prev);
                m_samples.push_back(s_now);
                if (m_samples.size() == OSR + 1) begin
                    e = 0;
                    for (int i = 1; i <= OSR; i++)
                        if (m_samples[i] != m_samples[i-1]) e++;
                    if (e > OSR) e = OSR;
                    if (e <= SPACE_MAX)     m_bit = 0;
                    else if (e >= MARK_MIN) m_bit = 1;
                    else                    e_err = 1;
                    e_bv = 1;
                    m_wbits.push_back(m_bit);
                    if (m_wbits.size() == WORD_W) begin
                        for (int i = 0; i < WORD_W; i++) m_word[WORD_W-1-i] = m_wbits[i];
                        e_wv = 1;
                        m_wbits.delete();
                    end
                    m_samples.delete();
                end
            end
        end else if (en_v) begin
            m_run = 1;
        end
        if (se_v) m_prev = s_now;
        m_d2 = m_d1;
        m_d1 = rx_v;
    endtask

    // One clock: drive at negedge, advance model at posedge, compare 1 ns later
    task automatic step(input bit en_v, input bit se_v, input bit rx_v);
        ev_t ev;
        @(negedge clk);
        en = en_v; sample_en = se_v; rx_in = rx_v;
        @(posedge clk);
        cyc++;
        model_edge(en_v, se_v, rx_v);
        #1;
        check("bit_valid",  32'(bit_valid),  32'(e_bv));
        check("sym_err",    32'(sym_err),    32'(e_err));
        check("word_valid", 32'(word_valid), 32'(e_wv));
        check("bit_out",    32'(bit_out),    32'(m_bit));
        check("word_out",   32'(word_out),   32'(m_word));
        check("busy",       32'(busy),       32'(m_run));
        if (bit_valid) begin
            ev.b = bit_out; ev.err = sym_err; ev.wv = word_valid; ev.w = word_out; ev.c = cyc;
            evq.push_back(ev);
        end
    endtask

    // One symbol of ntog toggles spaced per ticks, starting at the first tick
    task automatic send_sym(input int per, input int ntog, input int gap);
        for (int k = 0; k < OSR; k++) begin
            for (int g = 1; g < gap; g++) step(1, 0, cur_rx);
            if ((k % per == 0) && (k / per < ntog)) cur_rx = ~cur_rx;
            step(1, 1, cur_rx);
        end
    endtask

    // Continuous tone toggling every per ticks across symbol boundaries
    task automatic send_tone(input int per, input int nsym);
        for (int k = 0; k < OSR * nsym; k++) begin
            tphase++;
            if (tphase >= per) begin
                tphase = 0;
                cur_rx = ~cur_rx;
            end
            step(1, 1, cur_rx);
        end
    endtask

    task automatic send_bit(input bit b, input int gap);
        if (b) send_sym(1, 10, gap);
        else   send_sym(8, 2, gap);
    endtask

    task automatic idle_off();
        step(0, 0, cur_rx);
        step(0, 0, cur_rx);
    endtask

    task automatic start_run();
        step(1, 0, cur_rx);
    endtask

    task automatic send_word(input logic [WORD_W-1:0] w, input int gap, input string tag);
        int nwv;
        evq.delete();
        for (int i = WORD_W - 1; i >= 0; i--) send_bit(w[i], gap);
        step(1, 0, cur_rx);
        nwv = 0;
        foreach (evq[i]) if (evq[i].wv) nwv++;
        check({tag, "_nbits"}, 32'(evq.size()), 32'(WORD_W));
        check({tag, "_nwords"}, 32'(nwv), 32'd1);
        if (evq.size() == WORD_W) begin
            check({tag, "_wv_on_last_bit"}, 32'(evq[WORD_W-1].wv), 32'd1);
            check({tag, "_word"}, 32'(evq[WORD_W-1].w), 32'(w));
            check({tag, "_sym_period"}, 32'(evq[1].c - evq[0].c), 32'(OSR * gap));
        end
    endtask

    typedef struct {
        int per;
        int ntog;
        bit exp_bit;
        bit exp_err;
    } vec_t;

    initial begin
        vec_t vecs[10];
        ev_t  ev;
        bit   en_state;
        int   pct;

        vecs[0] = '{8, 2,  1'b0, 1'b0};  // space tone, 2 edges
        vecs[1] = '{1, 10, 1'b1, 1'b0};  // mark, 10 edges
        vecs[2] = '{3, 5,  1'b1, 1'b1};  // dead band holds 1
        vecs[3] = '{8, 2,  1'b0, 1'b0};  // space
        vecs[4] = '{2, 5,  1'b0, 1'b1};  // dead band holds 0
        vecs[5] = '{3, 4,  1'b0, 1'b0};  // exactly SPACE_MAX
        vecs[6] = '{1, 8,  1'b1, 1'b0};  // exactly MARK_MIN
        vecs[7] = '{1, 7,  1'b1, 1'b1};  // MARK_MIN-1, dead band
        vecs[8] = '{2, 5,  1'b1, 1'b1};  // SPACE_MAX+1, dead band
        vecs[9] = '{8, 2,  1'b0, 1'b0};  // space

        // Reset state
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {bit_out, bit_valid, sym_err, word_valid, busy}, 32'd0);
        check("reset_word", 32'(word_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table, one symbol at a time
        start_run();
        for (int i = 0; i < 10; i++) begin
            evq.delete();
            send_sym(vecs[i].per, vecs[i].ntog, 1);
            step(1, 0, cur_rx);
            check($sformatf("vec%0d_nevents", i), 32'(evq.size()), 32'd1);
            if (evq.size() == 1) begin
                ev = evq.pop_front();
                check($sformatf("vec%0d_bit", i), 32'(ev.b),   32'(vecs[i].exp_bit));
                check($sformatf("vec%0d_err", i), 32'(ev.err), 32'(vecs[i].exp_err));
            end
        end

        // Continuous tones: space, mark, and every-tick toggling at the count ceiling
        evq.delete();
        send_tone(8, 4);
        step(1, 0, cur_rx);
        check("space_tone_n", 32'(evq.size()), 32'd4);
        for (int i = 1; i < evq.size(); i++)
            check("space_tone_bit_err", {evq[i].b, evq[i].err}, 32'd0);
        evq.delete();
        send_tone(2, 4);
        step(1, 0, cur_rx);
        check("mark_tone_n", 32'(evq.size()), 32'd4);
        for (int i = 1; i < evq.size(); i++)
            check("mark_tone_bit_err", {evq[i].b, evq[i].err}, 32'd2);
        evq.delete();
        send_tone(1, 3);
        step(1, 0, cur_rx);
        check("sat_tone_n", 32'(evq.size()), 32'd3);
        for (int i = 0; i < evq.size(); i++)
            check("sat_tone_bit_err", {evq[i].b, evq[i].err}, 32'd2);

        // Word assembly from a clean word boundary
        idle_off();
        start_run();
        send_word(8'hA5, 1, "wA5");
        send_word(8'h3C, 1, "w3C");

        // en drops mid-word and mid-symbol, then a clean word
        evq.delete();
        send_bit(1'b1, 1); send_bit(1'b0, 1); send_bit(1'b1, 1);
        for (int k = 0; k < 8; k++) begin
            cur_rx = ~cur_rx;
            step(1, 1, cur_rx);
        end
        step(0, 1, cur_rx);
        step(0, 0, cur_rx);
        check("abort_no_strobe", 32'(evq.size()), 32'd3);
        start_run();
        send_word(8'hFF, 1, "wFF");

        // en falls on the final tick of a symbol: no decision
        evq.delete();
        for (int k = 0; k < OSR - 1; k++) step(1, 1, cur_rx);
        step(0, 1, cur_rx);
        step(0, 0, cur_rx);
        check("en_wins_final_tick", 32'(evq.size()), 32'd0);
        start_run();

        // Ticks every 4th clock stretch the symbol only
        send_word(8'hA5, 4, "wA5_gap4");

        // Asynchronous reset mid-symbol
        for (int k = 0; k < 5; k++) begin
            cur_rx = ~cur_rx;
            step(1, 1, cur_rx);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_outputs", {bit_out, bit_valid, sym_err, word_valid, busy}, 32'd0);
        check("async_rst_word", 32'(word_out), 32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        start_run();
        send_word(8'h5A, 1, "w5A_after_rst");

        // Randomised phase checked cycle by cycle against the model
        en_state = 1'b1;
        pct = 20;
        for (int n = 0; n < 6000; n++) begin
            if (n % 300 == 0) pct = $urandom_range(2, 60);
            if ($urandom_range(0, 399) == 0) en_state = ~en_state;
            if ($urandom_range(0, 99) < pct) cur_rx = ~cur_rx;
            step(en_state, ($urandom_range(0, 3) != 0), cur_rx);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
